// File: rtl/bp_fe_icache_flush_ctrl.sv
// rtl/bp_fe_icache_flush_ctrl.sv - I-cache set-clear sequencer for fences and single-set flushes
//
// Purpose:
//   Walks I-cache sets and issues one tag set-clear packet followed by one
//   stat (LRU) set-clear packet for each set. A command either walks every
//   set (flush_all_i=1) or clears only flush_index_i. The controller accepts
//   one command at a time and pulses done_o once when the walk completes.
//
// Ports:
//   clk_i            clock
//   reset_i          synchronous active-high reset
//   flush_v_i        flush command valid (held by requester until accepted)
//   flush_all_i      1 = walk all sets, 0 = clear flush_index_i only
//   flush_index_i    target set for a single-set flush
//   flush_ready_o    idle; command accepted on flush_v_i & flush_ready_o
//   tag_pkt_v_o      tag set-clear packet valid
//   tag_pkt_index_o  set to clear in the tag memory
//   tag_pkt_yumi_i   tag packet consumed
//   stat_pkt_v_o     stat set-clear packet valid
//   stat_pkt_index_o set to clear in the stat memory
//   stat_pkt_yumi_i  stat packet consumed
//   busy_o           flush in progress
//   done_o           one-cycle pulse at walk completion

module bp_fe_icache_flush_ctrl #(
    parameter  int sets_p         = 64,
    localparam int index_width_lp = (sets_p > 1) ? $clog2(sets_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      flush_v_i,
    input  logic                      flush_all_i,
    input  logic [index_width_lp-1:0] flush_index_i,
    output logic                      flush_ready_o,

    output logic                      tag_pkt_v_o,
    output logic [index_width_lp-1:0] tag_pkt_index_o,
    input  logic                      tag_pkt_yumi_i,

    output logic                      stat_pkt_v_o,
    output logic [index_width_lp-1:0] stat_pkt_index_o,
    input  logic                      stat_pkt_yumi_i,

    output logic                      busy_o,
    output logic                      done_o
);

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_tag   = 2'd1,
        e_stat  = 2'd2,
        e_done  = 2'd3
    } state_e;

    localparam logic [index_width_lp-1:0] last_set_lp = index_width_lp'(sets_p - 1);

    state_e                      r_state;
    state_e                      w_state_n;
    logic [index_width_lp-1:0]   r_index;
    logic [index_width_lp-1:0]   w_index_n;
    logic [index_width_lp-1:0]   r_last;
    logic [index_width_lp-1:0]   w_last_n;
    logic                        w_at_last;

    assign w_at_last = (r_index == r_last);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_ready;
            r_index <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_n;
            r_index <= w_index_n;
            r_last  <= w_last_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_index_n = r_index;
        w_last_n  = r_last;

        case (r_state)
            e_ready: begin
                if (flush_v_i) begin
                    // A full walk is just a range [0, sets_p-1]; a single-set
                    // flush is the degenerate range [idx, idx].
                    w_index_n = flush_all_i ? '0          : flush_index_i;
                    w_last_n  = flush_all_i ? last_set_lp : flush_index_i;
                    w_state_n = e_tag;
                end
            end
            e_tag: begin
                if (tag_pkt_yumi_i) begin
                    w_state_n = e_stat;
                end
            end
            e_stat: begin
                if (stat_pkt_yumi_i) begin
                    if (w_at_last) begin
                        w_state_n = e_done;
                    end else begin
                        // Never reached when r_index == r_last, so no wrap.
                        w_index_n = r_index + 1'b1;
                        w_state_n = e_tag;
                    end
                end
            end
            e_done: begin
                w_state_n = e_ready;
            end
            default: begin
                w_state_n = e_ready;
            end
        endcase
    end

    // All outputs decode registered state only; indices come straight from
    // r_index so they stay stable for the life of each packet.
    assign flush_ready_o    = (r_state == e_ready);
    assign tag_pkt_v_o      = (r_state == e_tag);
    assign stat_pkt_v_o     = (r_state == e_stat);
    assign busy_o           = (r_state != e_ready);
    assign done_o           = (r_state == e_done);
    assign tag_pkt_index_o  = r_index;
    assign stat_pkt_index_o = r_index;

endmodule

// File: tb/tb_bp_fe_icache_flush_ctrl.sv
// tb/tb_bp_fe_icache_flush_ctrl.sv - self-checking bench for bp_fe_icache_flush_ctrl

module tb_bp_fe_icache_flush_ctrl;

    localparam int N_SETS = 64;

    typedef struct packed {
        logic       ready;
        logic       tag_v;
        logic [5:0] tag_idx;
        logic       stat_v;
        logic [5:0] stat_idx;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        logic       fv;
        logic       fa;
        logic [5:0] fi;
        logic       ty;
        logic       sy;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       fv;
    logic       fa;
    logic [5:0] fi;
    logic       ty;
    logic       sy;

    logic       flush_ready;
    logic       tag_v;
    logic [5:0] tag_idx;
    logic       stat_v;
    logic [5:0] stat_idx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bp_fe_icache_flush_ctrl #(.sets_p(N_SETS)) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .flush_v_i        (fv),
        .flush_all_i      (fa),
        .flush_index_i    (fi),
        .flush_ready_o    (flush_ready),
        .tag_pkt_v_o      (tag_v),
        .tag_pkt_index_o  (tag_idx),
        .tag_pkt_yumi_i   (ty),
        .stat_pkt_v_o     (stat_v),
        .stat_pkt_index_o (stat_idx),
        .stat_pkt_yumi_i  (sy),
        .busy_o           (busy),
        .done_o           (done)
    );

    function automatic out_t mk(input logic r, input logic tv, input int ti,
                                input logic sv, input int si, input logic b, input logic d);
        out_t o;
        o.ready    = r;
        o.tag_v    = tv;
        o.tag_idx  = 6'(ti);
        o.stat_v   = sv;
        o.stat_idx = 6'(si);
        o.busy     = b;
        o.done     = d;
        return o;
    endfunction

    // Indices are only meaningful while the matching valid is expected.
    task automatic check(input string nm, input int c, input out_t e);
        logic ok;
        n_checks++;
        ok = (flush_ready === e.ready) && (tag_v === e.tag_v) && (stat_v === e.stat_v) &&
             (busy === e.busy) && (done === e.done) &&
             (!e.tag_v  || (tag_idx  === e.tag_idx)) &&
             (!e.stat_v || (stat_idx === e.stat_idx));
        if (!ok) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got rdy=%b tv=%b ti=%0d sv=%b si=%0d busy=%b done=%b, expected rdy=%b tv=%b ti=%0d sv=%b si=%0d busy=%b done=%b",
                     nm, c, flush_ready, tag_v, tag_idx, stat_v, stat_idx, busy, done,
                     e.ready, e.tag_v, e.tag_idx, e.stat_v, e.stat_idx, e.busy, e.done);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Closed-form schedule for a full walk accepted at cycle 0, with yumi
    // returned alongside each valid except for sn stall cycles on the tag
    // packet of set ss (ss < 0 means no stall).
    function automatic out_t exp_walk(input int c, input int n, input int ss, input int sn);
        int cc;
        if (c <= 2 * ss) begin
            cc = c;
        end else if (c <= 2 * ss + 1 + sn) begin
            return mk(0, 1, ss, 0, 0, 1, 0);
        end else begin
            cc = c - sn;
        end
        if (cc <= 2 * n) begin
            if (cc % 2 == 1) return mk(0, 1, (cc - 1) / 2, 0, 0, 1, 0);
            else             return mk(0, 0, 0, 1, (cc - 2) / 2, 1, 0);
        end
        if (cc == 2 * n + 1) return mk(0, 0, 0, 0, 0, 1, 1);
        return mk(1, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic run_walk(input string nm, input int ss, input int sn,
                            input int pulse_c, input int reset_c);
        int   last_c;
        out_t e;
        last_c = (reset_c > 0) ? reset_c : 2 * N_SETS + 2 + sn;
        fv = 1'b1; fa = 1'b1; fi = 6'd0; ty = 1'b0; sy = 1'b0;
        @(negedge clk);
        check(nm, 0, mk(1, 0, 0, 0, 0, 0, 0));
        next_cycle();
        for (int c = 1; c <= last_c; c++) begin
            e   = exp_walk(c, N_SETS, ss, sn);
            ty  = e.tag_v && !(c > 2 * ss && c <= 2 * ss + sn);
            sy  = e.stat_v;
            fv  = (c == pulse_c);
            fa  = 1'b0;
            fi  = 6'd9;
            rst = (c == reset_c);
            @(negedge clk);
            check(nm, c, e);
            next_cycle();
        end
        fv = 1'b0; ty = 1'b0; sy = 1'b0; rst = 1'b0;
    endtask

    vec_t vecs[16];

    initial begin
        // Single-set 37, yumi ignored while idle, stalled single-set 63,
        // then a back-to-back command with flush_v_i held during the walk.
        vecs[0]  = '{1, 0, 37, 0, 0, mk(1, 0, 0,  0, 0,  0, 0)};
        vecs[1]  = '{0, 0, 0,  1, 0, mk(0, 1, 37, 0, 0,  1, 0)};
        vecs[2]  = '{0, 0, 0,  0, 1, mk(0, 0, 0,  1, 37, 1, 0)};
        vecs[3]  = '{0, 0, 0,  0, 0, mk(0, 0, 0,  0, 0,  1, 1)};
        vecs[4]  = '{0, 0, 0,  1, 1, mk(1, 0, 0,  0, 0,  0, 0)};
        vecs[5]  = '{1, 0, 63, 0, 0, mk(1, 0, 0,  0, 0,  0, 0)};
        vecs[6]  = '{0, 0, 0,  0, 0, mk(0, 1, 63, 0, 0,  1, 0)};
        vecs[7]  = '{0, 0, 0,  1, 0, mk(0, 1, 63, 0, 0,  1, 0)};
        vecs[8]  = '{0, 0, 0,  0, 0, mk(0, 0, 0,  1, 63, 1, 0)};
        vecs[9]  = '{0, 0, 0,  1, 1, mk(0, 0, 0,  1, 63, 1, 0)};
        vecs[10] = '{0, 0, 0,  0, 0, mk(0, 0, 0,  0, 0,  1, 1)};
        vecs[11] = '{1, 0, 0,  0, 0, mk(1, 0, 0,  0, 0,  0, 0)};
        vecs[12] = '{1, 0, 5,  1, 0, mk(0, 1, 0,  0, 0,  1, 0)};
        vecs[13] = '{0, 0, 0,  0, 1, mk(0, 0, 0,  1, 0,  1, 0)};
        vecs[14] = '{0, 0, 0,  0, 0, mk(0, 0, 0,  0, 0,  1, 1)};
        vecs[15] = '{0, 0, 0,  0, 0, mk(1, 0, 0,  0, 0,  0, 0)};

        rst = 1'b1; fv = 1'b0; fa = 1'b0; fi = 6'd0; ty = 1'b0; sy = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b0;

        // Reset state and quiet idle.
        @(negedge clk);
        n_checks++;
        if (tag_idx !== 6'd0 || stat_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_index: got ti=%0d si=%0d, expected 0 0", tag_idx, stat_idx);
        end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            check("reset_idle", c, mk(1, 0, 0, 0, 0, 0, 0));
            next_cycle();
        end

        for (int i = 0; i < 16; i++) begin
            fv = vecs[i].fv; fa = vecs[i].fa; fi = vecs[i].fi;
            ty = vecs[i].ty; sy = vecs[i].sy;
            @(negedge clk);
            check("vector", i, vecs[i].exp);
            next_cycle();
        end
        fv = 1'b0; ty = 1'b0; sy = 1'b0;

        run_walk("full_walk", -1, 0, 0, 0);
        run_walk("backpressure", 5, 3, 0, 0);
        run_walk("busy_cmd", -1, 0, 40, 0);

        // Reset while set 20 is in e_stat (cycle 42 of the walk).
        run_walk("reset_mid", -1, 0, 0, 42);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("after_reset", c, mk(1, 0, 0, 0, 0, 0, 0));
            next_cycle();
        end
        fv = 1'b1; fa = 1'b0; fi = 6'd2;
        @(negedge clk); check("post_reset_flush", 0, mk(1, 0, 0, 0, 0, 0, 0)); next_cycle();
        fv = 1'b0; ty = 1'b1;
        @(negedge clk); check("post_reset_flush", 1, mk(0, 1, 2, 0, 0, 1, 0)); next_cycle();
        ty = 1'b0; sy = 1'b1;
        @(negedge clk); check("post_reset_flush", 2, mk(0, 0, 0, 1, 2, 1, 0)); next_cycle();
        sy = 1'b0;
        @(negedge clk); check("post_reset_flush", 3, mk(0, 0, 0, 0, 0, 1, 1)); next_cycle();
        @(negedge clk); check("post_reset_flush", 4, mk(1, 0, 0, 0, 0, 0, 0)); next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
